blink_period_meter: RTL and testbench

Receive-side companion to the LED blink counters. Samples an asynchronous square-wave input and measures each half-period in `sys_clk` cycles. Checks every measurement against an expected value and tolerance, and asserts `lock` after a run of consecutive good measurements. Used on boards and in benches to confirm that a blink or divider output has the intended rate.

---
 rtl/blink_period_meter.sv | 135 +++++++++++++
 tb/tb_blink_period_meter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/blink_period_meter.sv
// Measures half-periods of an async square wave in sys_clk cycles, range-checks each, asserts lock after LOCK_N good ones.
// Latency: sig_in transition -> meas_valid 3-4 cycles (2-FF sync + edge register + result register).
// Backpressure: none, results are pulsed on meas_valid; optional PERIOD_TIMEOUT_EN adds STALL state and timeout.
module blink_period_meter #(
    parameter int unsigned     CW       = 26,
    parameter logic [CW-1:0]   EXP_HALF = 26'd25_000_000,
    parameter logic [CW-1:0]   TOL      = 26'd1_000,
    parameter logic [2:0]      LOCK_N   = 3'd4,
    parameter logic [CW-1:0]   MAX_CNT  = 26'd50_000_000
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          sig_in,
    output logic [CW-1:0] half_period,
    output logic          meas_valid,
    output logic          in_range,
    output logic          lock,
    output logic          timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAS  = 2'd1
`ifdef PERIOD_TIMEOUT_EN
        ,
        STALL = 2'd2
`endif
    } state_t;

    state_t        state, state_nxt;
    logic          s1, s2, s3;
    logic          edge_det;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CW-1:0] diff;
    logic          cnt_ok;
    logic [2:0]    good_cnt, good_nxt;
    logic [CW-1:0] hp_nxt;
    logic          inr_nxt, mv_nxt, lock_nxt;
    logic          to_q, to_nxt;

    assign edge_det = s2 ^ s3;
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + CW'(1);
    assign diff     = (cnt >= EXP_HALF) ? cnt - EXP_HALF : EXP_HALF - cnt;
    assign cnt_ok   = (diff <= TOL);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hp_nxt    = half_period;
        inr_nxt   = in_range;
        mv_nxt    = 1'b0;
        good_nxt  = good_cnt;
        to_nxt    = to_q;
        case (state)
            IDLE: begin
                // First edge only arms the counter; there is no previous edge to measure from.
                if (edge_det) begin
                    state_nxt = MEAS;
                    cnt_nxt   = CW'(1);
                end
            end
            MEAS: begin
                if (edge_det) begin
                    hp_nxt   = cnt;
                    inr_nxt  = cnt_ok;
                    mv_nxt   = 1'b1;
                    cnt_nxt  = CW'(1);
                    if (!cnt_ok)
                        good_nxt = 3'd0;
                    else if (good_cnt != LOCK_N)
                        good_nxt = good_cnt + 3'd1;
                end
`ifdef PERIOD_TIMEOUT_EN
                else if (cnt == MAX_CNT) begin
                    state_nxt = STALL;
                    to_nxt    = 1'b1;
                    good_nxt  = 3'd0;
                end
`endif
                else begin
                    cnt_nxt = cnt_inc;
                end
            end
`ifdef PERIOD_TIMEOUT_EN
            STALL: begin
                if (edge_det) begin
                    state_nxt = MEAS;
                    cnt_nxt   = CW'(1);
                    to_nxt    = 1'b0;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
        lock_nxt = (good_nxt == LOCK_N);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            good_cnt    <= 3'd0;
            half_period <= '0;
            in_range    <= 1'b0;
            meas_valid  <= 1'b0;
            lock        <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            s1          <= sig_in;
            s2          <= s1;
            s3          <= s2;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            good_cnt    <= good_nxt;
            half_period <= hp_nxt;
            in_range    <= inr_nxt;
            meas_valid  <= mv_nxt;
            lock        <= lock_nxt;
            to_q        <= to_nxt;
        end
    end

`ifdef PERIOD_TIMEOUT_EN
    assign timeout = to_q;
`else
    // Without the stall path to_q never leaves 0 and MAX_CNT has no consumer.
    logic unused_max_cnt;
    assign unused_max_cnt = ^MAX_CNT;
    assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_blink_period_meter.sv
// Directed bench for blink_period_meter with EXP_HALF=10, TOL=1, LOCK_N=4, MAX_CNT=40, CW=6.
module tb_blink_period_meter;

    localparam int CW = 6;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          sig_in    = 1'b0;
    logic [CW-1:0] half_period;
    logic          meas_valid, in_range, lock, timeout;

    int checks = 0;
    int errors = 0;

    // Observations captured by half(): meas_valid pulse count over the window,
    // and outputs at the 3rd negedge after the toggle (where the result lands).
    int            o_mv;
    logic [CW-1:0] o_hp;
    logic          o_inr, o_lk, o_to;

    always #5 sys_clk = ~sys_clk;

    blink_period_meter #(
        .CW(CW), .EXP_HALF(6'd10), .TOL(6'd1), .LOCK_N(3'd4), .MAX_CNT(6'd40)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sig_in(sig_in),
        .half_period(half_period), .meas_valid(meas_valid), .in_range(in_range),
        .lock(lock), .timeout(timeout)
    );

    // Toggle sig_in then hold it for p cycles (p >= 3); called at a negedge.
    task automatic half(input int p);
        o_mv   = 0;
        sig_in = ~sig_in;
        for (int i = 1; i <= p; i++) begin
            @(negedge sys_clk);
            if (meas_valid === 1'b1) o_mv++;
            if (i == 3) begin
                o_hp  = half_period;
                o_inr = in_range;
                o_lk  = lock;
                o_to  = timeout;
            end
        end
    endtask

    function automatic logic [10:0] ex(input int mv, input int hp, input bit inr, input bit lk, input bit to);
        logic [1:0] m;
        logic [5:0] h;
        m = mv[1:0];
        h = hp[5:0];
        return {m, h, inr, lk, to};
    endfunction

    function automatic logic [10:0] obs();
        logic [1:0] m;
        m = o_mv[1:0];
        return {m, o_hp, o_inr, o_lk, o_to};
    endfunction

    task automatic test_reset;
        repeat (3) @(negedge sys_clk);
        checks++; if (half_period !== 6'd0) begin errors++; $display("FAIL reset_hp: got %0d expected 0", half_period); end
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_mv: got %b expected 0", meas_valid); end
        checks++; if (in_range !== 1'b0) begin errors++; $display("FAIL reset_inr: got %b expected 0", in_range); end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b expected 0", lock); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_to: got %b expected 0", timeout); end
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL idle_mv: got %b expected 0", meas_valid); end
    endtask

    task automatic test_lock;
        int p[5] = '{10, 10, 10, 10, 10};
        logic [10:0] e[5];
        e = '{ex(0, 0, 0, 0, 0), ex(1, 10, 1, 0, 0), ex(1, 10, 1, 0, 0), ex(1, 10, 1, 0, 0), ex(1, 10, 1, 1, 0)};
        for (int k = 0; k < 5; k++) begin
            half(p[k]);
            checks++;
            if (obs() !== e[k]) begin
                errors++;
                $display("FAIL lock step %0d: got {mv,hp,inr,lock,to}=%b expected %b", k, obs(), e[k]);
            end
        end
    endtask

    task automatic test_out_of_range;
        int p[6] = '{12, 10, 10, 10, 10, 10};
        logic [10:0] e[6];
        e = '{ex(1, 10, 1, 1, 0), ex(1, 12, 0, 0, 0), ex(1, 10, 1, 0, 0),
              ex(1, 10, 1, 0, 0), ex(1, 10, 1, 0, 0), ex(1, 10, 1, 1, 0)};
        for (int k = 0; k < 6; k++) begin
            half(p[k]);
            checks++;
            if (obs() !== e[k]) begin
                errors++;
                $display("FAIL out_of_range step %0d: got {mv,hp,inr,lock,to}=%b expected %b", k, obs(), e[k]);
            end
        end
    endtask

    task automatic test_alternating;
        int p[10] = '{9, 11, 9, 11, 8, 10, 10, 10, 10, 10};
        logic [10:0] e[10];
        e = '{ex(1, 10, 1, 1, 0), ex(1, 9, 1, 1, 0), ex(1, 11, 1, 1, 0), ex(1, 9, 1, 1, 0),
              ex(1, 11, 1, 1, 0), ex(1, 8, 0, 0, 0), ex(1, 10, 1, 0, 0), ex(1, 10, 1, 0, 0),
              ex(1, 10, 1, 0, 0), ex(1, 10, 1, 1, 0)};
        for (int k = 0; k < 10; k++) begin
            half(p[k]);
            checks++;
            if (obs() !== e[k]) begin
                errors++;
                $display("FAIL alternating step %0d: got {mv,hp,inr,lock,to}=%b expected %b", k, obs(), e[k]);
            end
        end
    endtask

    task automatic test_timeout;
        int mv_n = 0;
        // Continue the last 10-cycle window with sig_in frozen, up to 100 cycles after its toggle.
        for (int i = 11; i <= 100; i++) begin
            @(negedge sys_clk);
            if (meas_valid === 1'b1) mv_n++;
`ifdef PERIOD_TIMEOUT_EN
            if (i == 42) begin
                checks++;
                if ({timeout, lock} !== 2'b01) begin errors++; $display("FAIL timeout_pre: got {to,lock}=%b expected 01", {timeout, lock}); end
            end
            if (i == 43) begin
                checks++;
                if ({timeout, lock} !== 2'b10) begin errors++; $display("FAIL timeout_rise: got {to,lock}=%b expected 10", {timeout, lock}); end
            end
`else
            if (i == 43 || i == 100) begin
                checks++;
                if ({timeout, lock} !== 2'b01) begin errors++; $display("FAIL no_timeout: got {to,lock}=%b expected 01", {timeout, lock}); end
            end
`endif
        end
        checks++; if (mv_n != 0) begin errors++; $display("FAIL frozen_mv: got %0d pulses expected 0", mv_n); end

`ifdef PERIOD_TIMEOUT_EN
        mv_n   = 0;
        sig_in = ~sig_in;
        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk);
            if (meas_valid === 1'b1) mv_n++;
            if (i == 2) begin
                checks++;
                if (timeout !== 1'b1) begin errors++; $display("FAIL rearm_to_hold: got %b expected 1", timeout); end
            end
            if (i == 3) begin
                checks++;
                if ({timeout, lock, half_period} !== {1'b0, 1'b0, 6'd10}) begin
                    errors++; $display("FAIL rearm_clear: got {to,lock,hp}=%b expected 0_0_001010", {timeout, lock, half_period});
                end
            end
        end
        checks++; if (mv_n != 0) begin errors++; $display("FAIL rearm_mv: got %0d pulses expected 0", mv_n); end
`else
        half(10);
        checks++;
        if (obs() !== ex(1, 63, 0, 0, 0)) begin
            errors++; $display("FAIL saturated_meas: got {mv,hp,inr,lock,to}=%b expected %b", obs(), ex(1, 63, 0, 0, 0));
        end
`endif
        half(10);
        checks++;
        if (obs() !== ex(1, 10, 1, 0, 0)) begin
            errors++; $display("FAIL resume_meas: got {mv,hp,inr,lock,to}=%b expected %b", obs(), ex(1, 10, 1, 0, 0));
        end
    endtask

    task automatic test_edge_at_threshold;
        int p[2] = '{40, 10};
        logic [10:0] e[2];
        e = '{ex(1, 10, 1, 0, 0), ex(1, 40, 0, 0, 0)};
        for (int k = 0; k < 2; k++) begin
            half(p[k]);
            checks++;
            if (obs() !== e[k]) begin
                errors++;
                $display("FAIL threshold step %0d: got {mv,hp,inr,lock,to}=%b expected %b", k, obs(), e[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int p[4] = '{10, 10, 10, 10};
        logic [10:0] e[4];
        e = '{ex(1, 10, 1, 0, 0), ex(1, 10, 1, 0, 0), ex(1, 10, 1, 0, 0), ex(1, 10, 1, 1, 0)};
        for (int k = 0; k < 4; k++) begin
            half(p[k]);
            checks++;
            if (obs() !== e[k]) begin
                errors++;
                $display("FAIL relock step %0d: got {mv,hp,inr,lock,to}=%b expected %b", k, obs(), e[k]);
            end
        end
        // cnt reaches 5 at the 7th negedge after the toggle.
        sig_in = ~sig_in;
        repeat (7) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({half_period, meas_valid, in_range, lock, timeout} !== 10'd0) begin
            errors++; $display("FAIL reset_mid: got {hp,mv,inr,lock,to}=%b expected all 0",
                               {half_period, meas_valid, in_range, lock, timeout});
        end
        sig_in = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        half(10);
        checks++;
        if (obs() !== ex(0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL post_reset_arm: got {mv,hp,inr,lock,to}=%b expected %b", obs(), ex(0, 0, 0, 0, 0));
        end
        half(10);
        checks++;
        if (obs() !== ex(1, 10, 1, 0, 0)) begin
            errors++; $display("FAIL post_reset_meas: got {mv,hp,inr,lock,to}=%b expected %b", obs(), ex(1, 10, 1, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_out_of_range();
        test_alternating();
        test_timeout();
        test_edge_at_threshold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
